four_bit_mult_arbiter: RTL

Shares one `four_bit_comb_arr_multplr` between two requesters. A round-robin arbiter grants one request at a time and latches the operands into registers that drive the shared multiplier. The block then waits a programmable number of cycles for the combinational array to settle. It captures the 8-bit product and returns it to the winner with a one-cycle done pulse. The block sits between requester logic and the multiplier and can optionally feed `four_dig_svn_seg_display`.

---
 rtl/four_bit_mult_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/four_bit_mult_arbiter.sv
// four_bit_mult_arbiter
// Lets two requesters share one combinational 4x4 array multiplier.
// A round-robin arbiter picks one request, latches its operands into
// mul_a/mul_b, waits MUL_CYCLES edges for the array to settle, then
// captures mul_p into product and pulses done for the winner.
//
// Ports:
//   clk            clock, rising edge
//   clr            asynchronous active-low reset
//   req0/a0/b0     requester 0 request and operands
//   req1/a1/b1     requester 1 request and operands
//   gnt0/gnt1      one-cycle grant pulse (operands accepted)
//   done0/done1    one-cycle completion pulse for the owner
//   product        last captured product, held until next capture
//   busy           high while an operation is in flight
//   mul_a/mul_b    registered operands to the shared multiplier
//   mul_p          product from the shared multiplier
//   dig1..dig4     display nibbles (mul_a, mul_b, mul_p[7:4], mul_p[3:0])
//
// Build option: define FOUR_BIT_MULT_ARB_DISPLAY_EN to build the display
// registers; otherwise dig1..dig4 are tied to 0.
//
// MUL_CYCLES: edges from grant to product capture, legal range 1..15.
//
// state | meaning
// IDLE  | no operation in flight, arbitrating requests
// WAIT  | operands latched, counting down for the array to settle

module four_bit_mult_arbiter #(
   parameter int unsigned MUL_CYCLES = 2
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       req0,
   input  logic [3:0] a0,
   input  logic [3:0] b0,
   input  logic       req1,
   input  logic [3:0] a1,
   input  logic [3:0] b1,
   output logic       gnt0,
   output logic       gnt1,
   output logic       done0,
   output logic       done1,
   output logic [7:0] product,
   output logic       busy,
   output logic [3:0] mul_a,
   output logic [3:0] mul_b,
   input  logic [7:0] mul_p,
   output logic [3:0] dig1,
   output logic [3:0] dig2,
   output logic [3:0] dig3,
   output logic [3:0] dig4
);

   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

   localparam logic [3:0] CNT_LOAD = 4'(MUL_CYCLES - 1);

   state_t     state, state_nxt;
   logic       owner, owner_nxt;
   logic       last, last_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic [3:0] opa_nxt, opb_nxt;
   logic       gnt0_nxt, gnt1_nxt;
   logic       done0_nxt, done1_nxt;
   logic       cap;

   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      last_nxt  = last;
      cnt_nxt   = cnt;
      opa_nxt   = mul_a;
      opb_nxt   = mul_b;
      gnt0_nxt  = 1'b0;
      gnt1_nxt  = 1'b0;
      done0_nxt = 1'b0;
      done1_nxt = 1'b0;
      cap       = 1'b0;
      if (state == IDLE) begin
         // On a tie, last==1 means requester 1 went most recently, so 0 wins.
         if (req0 && (!req1 || last)) begin
            opa_nxt   = a0;
            opb_nxt   = b0;
            owner_nxt = 1'b0;
            last_nxt  = 1'b0;
            cnt_nxt   = CNT_LOAD;
            gnt0_nxt  = 1'b1;
            state_nxt = WAIT;
         end else if (req1) begin
            opa_nxt   = a1;
            opb_nxt   = b1;
            owner_nxt = 1'b1;
            last_nxt  = 1'b1;
            cnt_nxt   = CNT_LOAD;
            gnt1_nxt  = 1'b1;
            state_nxt = WAIT;
         end
      end else begin
         if (cnt != 4'd0) begin
            cnt_nxt = cnt - 4'd1;
         end else begin
            cap       = 1'b1;
            done0_nxt = ~owner;
            done1_nxt = owner;
            state_nxt = IDLE;
         end
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state   <= IDLE;
         owner   <= 1'b0;
         last    <= 1'b1;
         cnt     <= 4'd0;
         mul_a   <= 4'd0;
         mul_b   <= 4'd0;
         gnt0    <= 1'b0;
         gnt1    <= 1'b0;
         done0   <= 1'b0;
         done1   <= 1'b0;
         product <= 8'd0;
      end else begin
         state <= state_nxt;
         owner <= owner_nxt;
         last  <= last_nxt;
         cnt   <= cnt_nxt;
         mul_a <= opa_nxt;
         mul_b <= opb_nxt;
         gnt0  <= gnt0_nxt;
         gnt1  <= gnt1_nxt;
         done0 <= done0_nxt;
         done1 <= done1_nxt;
         if (cap) product <= mul_p;
      end
   end

   assign busy = (state == WAIT);

`ifdef FOUR_BIT_MULT_ARB_DISPLAY_EN
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         dig1 <= 4'd0;
         dig2 <= 4'd0;
         dig3 <= 4'd0;
         dig4 <= 4'd0;
      end else if (cap) begin
         dig1 <= mul_a;
         dig2 <= mul_b;
         dig3 <= mul_p[7:4];
         dig4 <= mul_p[3:0];
      end
   end
`else
   assign dig1 = 4'd0;
   assign dig2 = 4'd0;
   assign dig3 = 4'd0;
   assign dig4 = 4'd0;
`endif

endmodule
